// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch_unit (master) and
// instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over a req/ack bus and
// holds IWord until consumed. FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        IWord,
  output logic               iword_valid,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    HOLD
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        req, req_next;
  logic [31:0] iword_q, iword_next;
  logic        valid_q, valid_next;
  logic [31:0] pc_out_q, pc_out_next;
  logic        consume;
  logic        fetch_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_WAIT;
      pc       <= RESET_PC;
      req      <= 1'b0;
      iword_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      pc_out_q <= RESET_PC;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req      <= req_next;
      iword_q  <= iword_next;
      valid_q  <= valid_next;
      pc_out_q <= pc_out_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_next    = req;
    iword_next  = iword_q;
    valid_next  = valid_q;
    pc_out_next = pc_out_q;
    consume     = 1'b0;
    fetch_wait  = 1'b0;
    unique case (state)
      RST_WAIT: begin
        state_next = FETCH;
        req_next   = 1'b1;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          iword_next  = imem.imem_rdata;
          pc_out_next = pc;
          valid_next  = 1'b1;
          req_next    = 1'b0;
          state_next  = HOLD;
        end else begin
          fetch_wait = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          consume    = 1'b1;
          // Redirect targets are silently word-aligned by masking the low bits.
          pc_next    = redirect ? (redirect_pc & 32'hFFFF_FFFC) : pc + 32'd4;
          valid_next = 1'b0;
          iword_next = NOP_WORD;
          req_next   = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = RST_WAIT;
        req_next   = 1'b0;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (consume) fetch_count <= fetch_count + 32'd1;
      if (fetch_wait || (state == HOLD && stall)) stall_count <= stall_count + 32'd1;
    end
  end
`endif

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign IWord          = iword_q;
  assign iword_valid    = valid_q;
  assign pc_out         = pc_out_q;
  assign pc_plus4       = pc_out_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and wait-state fetches, stall,
// redirect, PC wrap and reset during an outstanding request.
module tb_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] IWord;
  logic        iword_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .IWord       (IWord),
    .iword_valid (iword_valid),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, imem.imem_req}, 32'd1);
    check({tag, "_addr"}, imem.imem_addr, addr);
    check({tag, "_valid"}, {31'd0, iword_valid}, 32'd0);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] word, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, iword_valid}, 32'd1);
    check({tag, "_iword"}, IWord, word);
    check({tag, "_pc"}, pc_out, pc);
    check({tag, "_pc4"}, pc_plus4, pc + 32'd4);
    check({tag, "_req"}, {31'd0, imem.imem_req}, 32'd0);
  endtask

  // Acknowledge the pending request in the current cycle, then drop ack.
  task automatic ack_word(input logic [31:0] word);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    step();
    imem.imem_ack   = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;

    // Reset
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_iword", IWord, 32'h13);
      check("rst_valid", {31'd0, iword_valid}, 32'd0);
      check("rst_req", {31'd0, imem.imem_req}, 32'd0);
    end
    check("rst_pc", pc_out, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_wait_req", {31'd0, imem.imem_req}, 32'd0);
    step();
    check_fetch("first", 32'h0);

    // Zero-wait fetches
    ack_word(32'h0050_0093);
    check_hold("zw0", 32'h0050_0093, 32'h0);
    step();
    check_fetch("zw_next", 32'h4);
    ack_word(32'h00A0_0113);
    check_hold("zw1", 32'h00A0_0113, 32'h4);

    // Stall in HOLD; a stray ack must not be captured
    stall           = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check_hold("stall", 32'h00A0_0113, 32'h4);
    end
    imem.imem_ack = 1'b0;
    stall         = 1'b0;
    step();
    check_fetch("stall_rel", 32'h8);

    // Wait states
    for (int i = 0; i < 3; i++) begin
      step();
      check_fetch("wait", 32'h8);
    end
    ack_word(32'h0030_0193);
    check_hold("wait_ack", 32'h0030_0193, 32'h8);

    // Walk to pc 0x10
    step();
    check_fetch("to_c", 32'hC);
    ack_word(32'h0000_0001);
    step();
    check_fetch("to_10", 32'h10);
    ack_word(32'h0000_0002);
    check_hold("at_10", 32'h0000_0002, 32'h10);

    // Redirect: ignored while stalled, taken and aligned on consume
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    stall       = 1'b1;
    step();
    check_hold("redir_stall", 32'h0000_0002, 32'h10);
    stall = 1'b0;
    step();
    check_fetch("redir", 32'h40);
    // Still asserted in FETCH: no effect
    ack_word(32'h0000_0003);
    check_hold("redir_fetch", 32'h0000_0003, 32'h40);
    redirect = 1'b0;
    step();
    check_fetch("after_redir", 32'h44);
    ack_word(32'h0000_0004);

    // Wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    check_fetch("top", 32'hFFFF_FFFC);
    ack_word(32'h0000_0005);
    check_hold("top_hold", 32'h0000_0005, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    step();
    check_fetch("wrap", 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_count, 32'd8);
`endif

    // Reset during FETCH with ack arriving while in reset
    step();
    check_fetch("pre_rst", 32'h0);
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem.imem_req}, 32'd0);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst2_iword", IWord, 32'h13);
      check("rst2_valid", {31'd0, iword_valid}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rst2_req", {31'd0, imem.imem_req}, 32'd0);
    step();
    check_fetch("late_ack", 32'h0);
    check("late_iword", IWord, 32'h13);
    imem.imem_ack = 1'b0;
    step();
    check_fetch("restart", 32'h0);
    ack_word(32'h0010_0073);
    check_hold("restart", 32'h0010_0073, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt_rst", fetch_count, 32'd0);
    check("stall_cnt_rst", stall_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
